// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: UART receiver with configurable width, stop bits and divisor, runtime parity select, error flags and a one-deep valid/ready output buffer.
module uart_rx_cfg #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 5208,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx,
  input  logic [1:0]            parity_mode,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  parity_err,
  output logic                  frame_err,
  output logic                  break_det,
  output logic                  overrun,
  input  logic                  ovr_clr,
  output logic                  busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_WIDTH + 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK_WAIT} state_t;
  state_t state, state_n;
  logic meta, rx_s;
  logic [CW-1:0] cnt;
  logic [BW-1:0] bit_cnt;
  logic [DATA_WIDTH-1:0] sh;
  logic [1:0] mode;
  logic par_en, tick, last_data, done, par_bad, par_one, stop_zero, stop_one, frame_bad, brk;
  assign par_en    = mode == 2'b01 || mode == 2'b10;
  // start bit is sampled at mid-bit, every later bit one full period after the previous sample
  assign tick      = state == START ? cnt == CW'(CLKS_PER_BIT / 2 - 1) : cnt == CW'(CLKS_PER_BIT - 1);
  assign last_data = bit_cnt == BW'(DATA_WIDTH - 1);
  assign done      = state == STOP && tick && bit_cnt == BW'(STOP_BITS - 1);
  assign frame_bad = stop_zero | ~rx_s;
  assign brk       = sh == '0 && !par_one && !stop_one && !rx_s;
  always_ff @(posedge clk)
    state <= !rst_n ? IDLE : state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:     if (!rx_s) state_n = START;
      START:    if (tick) state_n = rx_s ? IDLE : DATA;
      DATA:     if (tick && last_data) state_n = par_en ? PARITY : STOP;
      PARITY:   if (tick) state_n = STOP;
      STOP:     if (done) state_n = rx_s ? IDLE : BRK_WAIT;
      BRK_WAIT: if (rx_s) state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end
  always_comb busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta      <= 1'b1;
      rx_s      <= 1'b1;
      cnt       <= '0;
      bit_cnt   <= '0;
      sh        <= '0;
      mode      <= '0;
      par_bad   <= 1'b0;
      par_one   <= 1'b0;
      stop_zero <= 1'b0;
      stop_one  <= 1'b0;
    end else begin
      {rx_s, meta} <= {meta, rx};
      cnt     <= (state_n != state || tick) ? '0 : cnt + 1'b1;
      bit_cnt <= state_n != state ? '0 : bit_cnt + BW'(tick && (state == DATA || state == STOP));
      if (state == START && tick) mode <= parity_mode;
      if (state == DATA && tick) sh <= {rx_s, sh[DATA_WIDTH-1:1]};
      if (state == START) {par_bad, par_one, stop_zero, stop_one} <= '0;
      if (state == PARITY && tick) begin
        par_bad <= ^sh ^ rx_s ^ mode[1];
        par_one <= rx_s;
      end
      if (state == STOP && tick) begin
        stop_zero <= stop_zero | ~rx_s;
        stop_one  <= stop_one | rx_s;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      break_det  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (done && (!rx_valid || rx_ready)) begin
        rx_data    <= sh;
        rx_valid   <= 1'b1;
        parity_err <= par_bad;
        frame_err  <= frame_bad;
        break_det  <= brk;
      end else if (rx_ready) rx_valid <= 1'b0;
      overrun <= (done && rx_valid && !rx_ready) | (overrun & ~ovr_clr);
    end
  end
endmodule
